// File: rtl/pll_clkgen_pkg.sv
// -----------------------------------------------------------------------------
// pll_clkgen_pkg
// Shared types and constants for the pll_clkgen clock-enable generator.
//   state_t     : lock-qualification FSM states
//   ch_cfg_t    : one channel's {div, phase} configuration record
//   CH_IDX_W()  : width of a channel index, never less than one bit
//   LOSS_CNT_W  : width of the optional lock-loss counter
//                 (present only when PLL_CLKGEN_LOSS_CNT_EN is defined)
// The record fields are CFG_FIELD_W bits wide; a pll_clkgen instance uses
// the low DIV_W bits, so DIV_W must not exceed CFG_FIELD_W.
// -----------------------------------------------------------------------------
package pll_clkgen_pkg;

    typedef enum logic [1:0] {
        RESET     = 2'd0,
        WAIT_LOCK = 2'd1,
        SETTLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int CFG_FIELD_W = 16;
    localparam int LOSS_CNT_W  = 16;

    typedef struct packed {
        logic [CFG_FIELD_W-1:0] div;
        logic [CFG_FIELD_W-1:0] phase;
    } ch_cfg_t;

    // Divide-by-one with zero phase: every channel strobes every cycle.
    localparam ch_cfg_t CFG_RESET = '{div: CFG_FIELD_W'(1), phase: '0};

    function automatic int CH_IDX_W(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/pll_clkgen_div_ch.sv
// -----------------------------------------------------------------------------
// pll_clkgen_div_ch
// One clock-enable channel: active divide/phase registers, a free-running
// 0..N-1 counter and the registered ce strobe.
// Ports:
//   refclk    : clock
//   rst       : asynchronous active-low reset
//   run       : the generator is in RUN for the coming cycle
//   realign   : force the counter to zero on this edge
//   load      : copy load_cfg into the active registers on this edge
//   load_cfg  : incoming {div, phase} (low DIV_W bits used)
//   ce        : strobe, high in the cycle the counter equals the phase
// -----------------------------------------------------------------------------
module pll_clkgen_div_ch
    import pll_clkgen_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic    refclk,
    input  logic    rst,
    input  logic    run,
    input  logic    realign,
    input  logic    load,
    input  ch_cfg_t load_cfg,
    output logic    ce
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] phase_q;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] div_n;
    logic [DIV_W-1:0] phase_n;
    logic [DIV_W-1:0] cnt_n;
    logic [DIV_W-1:0] new_div;
    logic [DIV_W-1:0] new_phase;
    logic             ce_n;

    assign new_div   = load_cfg.div[DIV_W-1:0];
    assign new_phase = load_cfg.phase[DIV_W-1:0];

    // ce is registered from the counter value of the coming cycle, so the
    // strobe lines up with the cycle in which the counter equals the phase.
    // A phase at or beyond the divide ratio is clamped to the last count;
    // a zero divide ratio parks the counter and silences the channel.
    always_comb begin
        div_n   = div_q;
        phase_n = phase_q;
        cnt_n   = '0;
        if (load) begin
            div_n = new_div;
            if (new_div == '0) begin
                phase_n = '0;
            end else if (new_phase >= new_div) begin
                phase_n = new_div - ONE;
            end else begin
                phase_n = new_phase;
            end
        end
        if (run && !realign && (div_n != '0)) begin
            if (cnt_q >= div_n - ONE) begin
                cnt_n = '0;
            end else begin
                cnt_n = cnt_q + ONE;
            end
        end
        ce_n = run && (div_n != '0) && (cnt_n == phase_n);
    end

    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            div_q   <= ONE;
            phase_q <= '0;
            cnt_q   <= '0;
            ce      <= 1'b0;
        end else begin
            div_q   <= div_n;
            phase_q <= phase_n;
            cnt_q   <= cnt_n;
            ce      <= ce_n;
        end
    end

endmodule

// File: rtl/pll_clkgen.sv
// -----------------------------------------------------------------------------
// pll_clkgen
// Multi-channel clock-enable generator in the PLL output domain. The raw PLL
// lock is synchronised and must hold for SETTLE_CYCLES before the generator
// runs. Each channel has a shadow {div, phase} written through a valid/ready
// port and copied to the active registers on cfg_commit; a commit while
// running realigns every channel counter and pulses resync_pulse.
// Ports:
//   refclk        : clock (PLL output domain)
//   rst           : asynchronous active-low reset
//   pll_locked_in : raw PLL lock, asynchronous
//   cfg_valid     : config write request
//   cfg_ready     : write accepted when cfg_valid & cfg_ready
//   cfg_ch        : target channel (out-of-range writes are dropped)
//   cfg_div       : divide ratio N (0 disables the channel)
//   cfg_phase     : phase offset P
//   cfg_commit    : copy all shadows to active, realign when running
//   ce_out        : per-channel clock-enable strobes
//   locked        : qualified lock
//   resync_pulse  : one-cycle pulse on counter realignment
//   loss_count    : saturating RUN->WAIT_LOCK count, only with
//                   `define PLL_CLKGEN_LOSS_CNT_EN
// -----------------------------------------------------------------------------
module pll_clkgen
    import pll_clkgen_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int DIV_W         = 16,
    parameter int SETTLE_CYCLES = 1024,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                         refclk,
    input  logic                         rst,
    input  logic                         pll_locked_in,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [CH_IDX_W(NUM_CH)-1:0]  cfg_ch,
    input  logic [DIV_W-1:0]             cfg_div,
    input  logic [DIV_W-1:0]             cfg_phase,
    input  logic                         cfg_commit,
    output logic [NUM_CH-1:0]            ce_out,
    output logic                         locked,
    output logic                         resync_pulse
`ifdef PLL_CLKGEN_LOSS_CNT_EN
    ,
    output logic [LOSS_CNT_W-1:0]        loss_count
`endif
);

    localparam int CH_W  = CH_IDX_W(NUM_CH);
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

    state_t                 state_q;
    state_t                 state_n;
    logic [SET_W-1:0]       settle_q;
    logic [SET_W-1:0]       settle_n;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    logic                   wr_fire;
    logic                   ch_run;
    logic                   ch_realign;
    logic                   run_commit;
    ch_cfg_t                wr_cfg;

    // Plain flop chain; lock_s is the last stage.
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked_in};
        end
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            state_q  <= RESET;
            settle_q <= '0;
        end else begin
            state_q  <= state_n;
            settle_q <= settle_n;
        end
    end

    // The settle counter only advances in SETTLE; any lock drop there
    // discards the partial count so a later attempt waits the full period.
    always_comb begin
        state_n  = state_q;
        settle_n = '0;
        case (state_q)
            RESET: begin
                state_n = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_n = SETTLE;
                end
            end
            SETTLE: begin
                if (!lock_s) begin
                    state_n = WAIT_LOCK;
                end else if (settle_q == SETTLE_LAST) begin
                    state_n = RUN;
                end else begin
                    settle_n = settle_q + SET_W'(1);
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_n = WAIT_LOCK;
                end
            end
            default: begin
                state_n = RESET;
            end
        endcase
    end

    // Channels run whenever the next state is RUN. Counters restart both on
    // entry to RUN and on a commit that keeps us in RUN; only the latter is
    // announced on resync_pulse. A commit coinciding with lock loss still
    // copies the shadows but produces no pulse.
    assign ch_run     = (state_n == RUN);
    assign run_commit = cfg_commit && (state_q == RUN) && ch_run;
    assign ch_realign = ch_run && ((state_q != RUN) || cfg_commit);

    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            cfg_ready    <= 1'b0;
            locked       <= 1'b0;
            resync_pulse <= 1'b0;
        end else begin
            cfg_ready    <= (state_n != RESET);
            locked       <= ch_run;
            resync_pulse <= run_commit;
        end
    end

    assign wr_fire = cfg_valid && cfg_ready;
    assign wr_cfg  = '{div: CFG_FIELD_W'(cfg_div), phase: CFG_FIELD_W'(cfg_phase)};

    // A write in the same cycle as a commit is forwarded straight into the
    // commit data so the committed set includes it. An index with no
    // matching channel hits nothing, which drops the write.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic    wr_hit;
        ch_cfg_t shadow_q;
        ch_cfg_t commit_cfg;

        assign wr_hit     = wr_fire && (cfg_ch == CH_W'(i));
        assign commit_cfg = wr_hit ? wr_cfg : shadow_q;

        always_ff @(posedge refclk or negedge rst) begin
            if (!rst) begin
                shadow_q <= CFG_RESET;
            end else if (wr_hit) begin
                shadow_q <= wr_cfg;
            end
        end

        pll_clkgen_div_ch #(
            .DIV_W (DIV_W)
        ) u_div_ch (
            .refclk   (refclk),
            .rst      (rst),
            .run      (ch_run),
            .realign  (ch_realign),
            .load     (cfg_commit),
            .load_cfg (commit_cfg),
            .ce       (ce_out[i])
        );
    end

`ifdef PLL_CLKGEN_LOSS_CNT_EN
    logic [LOSS_CNT_W-1:0] loss_q;

    // Counts only genuine losses from RUN and sticks at all-ones.
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            loss_q <= '0;
        end else if ((state_q == RUN) && (state_n == WAIT_LOCK) && (loss_q != '1)) begin
            loss_q <= loss_q + LOSS_CNT_W'(1);
        end
    end

    assign loss_count = loss_q;
`endif

endmodule

// File: tb/tb_pll_clkgen.sv
// -----------------------------------------------------------------------------
// tb_pll_clkgen
// Directed bench for pll_clkgen with NUM_CH=5 (3-bit cfg_ch, so index 5 is
// out of range), SETTLE_CYCLES=16 and SYNC_STAGES=2. Channel programming is
// table driven; lock acquisition, settle abort and lock loss are hand
// sequences. Build with PLL_CLKGEN_LOSS_CNT_EN to exercise loss_count.
// -----------------------------------------------------------------------------
module tb_pll_clkgen;
    import pll_clkgen_pkg::*;

    localparam int NUM_CH = 5;
    localparam int DIV_W  = 16;
    localparam int SETTLE = 16;
    localparam int SYNC   = 2;
    localparam int ACQ    = SYNC + 1 + SETTLE;

    logic              refclk = 1'b0;
    logic              rst = 1'b0;
    logic              pll_locked_in = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [2:0]        cfg_ch = '0;
    logic [DIV_W-1:0]  cfg_div = '0;
    logic [DIV_W-1:0]  cfg_phase = '0;
    logic              cfg_commit = 1'b0;
    logic [NUM_CH-1:0] ce_out;
    logic              locked;
    logic              resync_pulse;
`ifdef PLL_CLKGEN_LOSS_CNT_EN
    logic [15:0]       loss_count;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        valid;
        logic [2:0]  ch;
        logic [15:0] div;
        logic [15:0] phase;
        logic        commit;
        logic [4:0]  exp_ce;
        logic        exp_resync;
    } vec_t;

    vec_t vecs[$];

    pll_clkgen #(
        .NUM_CH        (NUM_CH),
        .DIV_W         (DIV_W),
        .SETTLE_CYCLES (SETTLE),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .refclk        (refclk),
        .rst           (rst),
        .pll_locked_in (pll_locked_in),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_ch        (cfg_ch),
        .cfg_div       (cfg_div),
        .cfg_phase     (cfg_phase),
        .cfg_commit    (cfg_commit),
        .ce_out        (ce_out),
        .locked        (locked),
        .resync_pulse  (resync_pulse)
`ifdef PLL_CLKGEN_LOSS_CNT_EN
        ,
        .loss_count    (loss_count)
`endif
    );

    always #5 refclk = ~refclk;

    // Hard stop in case something stalls the stimulus.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge refclk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic valid, input logic [2:0] ch,
                                  input logic [15:0] div, input logic [15:0] phase,
                                  input logic commit);
        cfg_valid  = valid;
        cfg_ch     = ch;
        cfg_div    = div;
        cfg_phase  = phase;
        cfg_commit = commit;
        step();
        cfg_valid  = 1'b0;
        cfg_commit = 1'b0;
    endtask

    task automatic add_vec(input logic valid, input logic [2:0] ch, input logic [15:0] div,
                           input logic [15:0] phase, input logic commit,
                           input logic [4:0] exp_ce, input logic exp_resync);
        vec_t v;
        v.valid = valid; v.ch = ch; v.div = div; v.phase = phase; v.commit = commit;
        v.exp_ce = exp_ce; v.exp_resync = exp_resync;
        vecs.push_back(v);
    endtask

    task automatic idle(input logic [4:0] exp_ce);
        add_vec(1'b0, 3'd0, 16'd0, 16'd0, 1'b0, exp_ce, 1'b0);
    endtask

    // Raise the raw lock and expect locked exactly ACQ edges later.
    task automatic acquire_lock(input string tag);
        pll_locked_in = 1'b1;
        for (int i = 1; i <= ACQ; i++) begin
            step();
            check_output($sformatf("%s locked@%0d", tag, i), 32'(locked), 32'(i == ACQ));
        end
    endtask

    // Drop the raw lock from RUN; locked/ce fall on the third edge.
    task automatic lose_lock(input string tag, input logic commit_on_loss);
        pll_locked_in = 1'b0;
        step();
        check_output({tag, " locked@1"}, 32'(locked), 32'd1);
        step();
        check_output({tag, " locked@2"}, 32'(locked), 32'd1);
        cfg_commit = commit_on_loss;
        step();
        cfg_commit = 1'b0;
        check_output({tag, " locked@3"}, 32'(locked), 32'd0);
        check_output({tag, " ce@3"}, 32'(ce_out), 32'd0);
        check_output({tag, " resync@3"}, 32'(resync_pulse), 32'd0);
    endtask

    initial begin
        // Channel programming table, one row per edge, all in RUN.
        add_vec(1'b1, 3'd0, 16'd4, 16'd1, 1'b0, 5'b11111, 1'b0);
        add_vec(1'b1, 3'd1, 16'd6, 16'd5, 1'b0, 5'b11111, 1'b0);
        add_vec(1'b0, 3'd0, 16'd0, 16'd0, 1'b1, 5'b11100, 1'b1);
        idle(5'b11101); idle(5'b11100); idle(5'b11100); idle(5'b11100);
        idle(5'b11111); idle(5'b11100); idle(5'b11100); idle(5'b11100);
        idle(5'b11101); idle(5'b11100); idle(5'b11110); idle(5'b11100);
        add_vec(1'b1, 3'd2, 16'd3, 16'd7, 1'b0, 5'b11101, 1'b0);
        add_vec(1'b0, 3'd0, 16'd0, 16'd0, 1'b1, 5'b11000, 1'b1);
        idle(5'b11001); idle(5'b11100); idle(5'b11000); idle(5'b11000);
        idle(5'b11111); idle(5'b11000); idle(5'b11000); idle(5'b11100);
        add_vec(1'b1, 3'd2, 16'd0, 16'd0, 1'b0, 5'b11001, 1'b0);
        add_vec(1'b1, 3'd5, 16'd2, 16'd1, 1'b0, 5'b11000, 1'b0);
        add_vec(1'b0, 3'd0, 16'd0, 16'd0, 1'b1, 5'b11000, 1'b1);
        idle(5'b11001); idle(5'b11000); idle(5'b11000); idle(5'b11000);
        idle(5'b11011); idle(5'b11000);
        add_vec(1'b1, 3'd3, 16'd2, 16'd0, 1'b1, 5'b11000, 1'b1);
        idle(5'b10001); idle(5'b11000); idle(5'b10000); idle(5'b11000);
        idle(5'b10011); idle(5'b11000);

        // Reset state, before and after a clock edge under reset.
        #2;
        check_output("reset ce", 32'(ce_out), 32'd0);
        check_output("reset locked", 32'(locked), 32'd0);
        check_output("reset resync", 32'(resync_pulse), 32'd0);
        check_output("reset ready", 32'(cfg_ready), 32'd0);
        step();
        check_output("reset ready edge", 32'(cfg_ready), 32'd0);
        check_output("reset ce edge", 32'(ce_out), 32'd0);
        @(negedge refclk);
        rst = 1'b1;
        #1;
        check_output("release ready", 32'(cfg_ready), 32'd0);
        step();
        check_output("wait_lock ready", 32'(cfg_ready), 32'd1);
        check_output("wait_lock locked", 32'(locked), 32'd0);

        // First lock; default config strobes every channel every cycle.
        acquire_lock("acquire");
        check_output("run entry ce", 32'(ce_out), 32'h1f);
        check_output("run entry resync", 32'(resync_pulse), 32'd0);

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].valid, vecs[i].ch, vecs[i].div, vecs[i].phase,
                           vecs[i].commit);
            check_output($sformatf("vec%0d ce", i), 32'(ce_out), 32'(vecs[i].exp_ce));
            check_output($sformatf("vec%0d resync", i), 32'(resync_pulse),
                         32'(vecs[i].exp_resync));
            check_output($sformatf("vec%0d locked", i), 32'(locked), 32'd1);
        end

        lose_lock("loss1", 1'b0);
`ifdef PLL_CLKGEN_LOSS_CNT_EN
        check_output("loss_count 1", 32'(loss_count), 32'd1);
`endif
        check_output("ready after loss", 32'(cfg_ready), 32'd1);

        // Abort the settle at count 10, then a full settle must follow.
        pll_locked_in = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            step();
            check_output($sformatf("settle locked@%0d", i), 32'(locked), 32'd0);
        end
        pll_locked_in = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            check_output($sformatf("abort locked@%0d", i), 32'(locked), 32'd0);
        end
        acquire_lock("reacquire");
        check_output("reacquire ce", 32'(ce_out), 32'h18);

        // Shadow write in RUN leaves active untouched; commit lands on loss.
        apply_stimulus(1'b1, 3'd4, 16'd3, 16'd0, 1'b0);
        check_output("shadow only ce4", 32'(ce_out[4]), 32'd1);
        lose_lock("loss2", 1'b1);
`ifdef PLL_CLKGEN_LOSS_CNT_EN
        check_output("loss_count 2", 32'(loss_count), 32'd2);
`endif
        acquire_lock("acq3");
        check_output("commit-on-loss t0", 32'(ce_out), 32'h18);
        step();
        check_output("commit-on-loss t1", 32'(ce_out), 32'h01);
        step();
        check_output("commit-on-loss t2", 32'(ce_out), 32'h08);
        step();
        check_output("commit-on-loss t3", 32'(ce_out), 32'h10);

        lose_lock("loss3", 1'b0);
        acquire_lock("acq4");
        lose_lock("loss4", 1'b0);
`ifdef PLL_CLKGEN_LOSS_CNT_EN
        check_output("loss_count 4", 32'(loss_count), 32'd4);
`endif
        step();
        check_output("idle ce", 32'(ce_out), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
